// File: rtl/rtc_adj_ctrl.sv
// Command sequencer/arbiter for the RTC: serialises host and servo commands and
// drives the time, period and one-shot adjustment load strobes. Optional macro:
// RTC_ADJ_CTRL_SLEW_EN (defined: offsets are split into STEP_MAX-bounded steps).
module rtc_adj_ctrl #(
  parameter logic [39:0] STEP_MAX  = 40'h00_4000_0000,
  parameter logic [31:0] ADJ_DELAY = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic [1:0]  host_op,
  input  logic [37:0] host_ns,
  input  logic [47:0] host_sec,
  input  logic [39:0] host_val,
  output logic        host_ack,
  input  logic        srv_req,
  input  logic        srv_op,
  input  logic [39:0] srv_val,
  output logic        srv_ack,
  output logic        busy,
  output logic        time_ld,
  output logic [37:0] time_reg_ns_in,
  output logic [47:0] time_reg_sec_in,
  output logic        period_ld,
  output logic [39:0] period_in,
  output logic        adj_ld,
  output logic [31:0] adj_ld_data,
  output logic [39:0] period_adj
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TIME,
    S_PERIOD,
    S_STEP,
    S_WAIT
  } state_t;

  state_t      state, state_d;
  logic [39:0] remaining;
  logic [39:0] step;
  logic [39:0] adj_q;
  logic [32:0] wait_cnt;
  logic        slewing;
  logic        abort;
  logic        host_take;
  logic        srv_take;

  // A host time set preempts an in-flight slew; everything else waits for IDLE.
  assign slewing   = (state == S_STEP) || (state == S_WAIT);
  assign abort     = slewing && host_req && (host_op == 2'b00);
  assign host_take = rst && (((state == S_IDLE) && host_req) || abort);
  assign srv_take  = rst && (state == S_IDLE) && srv_req && !host_req;

  assign host_ack    = host_take;
  assign srv_ack     = srv_take;
  assign busy        = (state != S_IDLE);
  assign time_ld     = (state == S_TIME);
  assign period_ld   = (state == S_PERIOD);
  assign adj_ld      = (state == S_STEP) && !abort;
  assign adj_ld_data = adj_ld ? ADJ_DELAY : 32'd0;
  assign period_adj  = adj_ld ? step : adj_q;

`ifdef RTC_ADJ_CTRL_SLEW_EN
  localparam logic signed [39:0] STEP_POS = STEP_MAX;
  localparam logic signed [39:0] STEP_NEG = -STEP_POS;

  always_comb begin
    step = remaining;
    if ($signed(remaining) > STEP_POS) begin
      step = STEP_POS;
    end else if ($signed(remaining) < STEP_NEG) begin
      step = STEP_NEG;
    end
  end
`else
  always_comb begin
    step = remaining;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned
    // (which would infer a latch).
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (host_req) begin
          unique case (host_op)
            2'b00:   state_d = S_TIME;
            2'b01:   state_d = S_PERIOD;
            2'b10:   state_d = (host_val != 40'd0) ? S_STEP : S_IDLE;
            default: state_d = S_IDLE;
          endcase
        end else if (srv_req) begin
          if (srv_op) begin
            state_d = (srv_val != 40'd0) ? S_STEP : S_IDLE;
          end else begin
            state_d = S_PERIOD;
          end
        end
      end
      S_TIME, S_PERIOD: state_d = S_IDLE;
      S_STEP: state_d = abort ? S_TIME : S_WAIT;
      S_WAIT: begin
        if (abort) begin
          state_d = S_TIME;
        end else if (wait_cnt == 33'd0) begin
          state_d = (remaining != 40'd0) ? S_STEP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_reg_ns_in  <= '0;
      time_reg_sec_in <= '0;
      period_in       <= '0;
      remaining       <= '0;
      adj_q           <= '0;
      wait_cnt        <= '0;
    end else begin
      if (host_take && (host_op == 2'b00)) begin
        time_reg_ns_in  <= host_ns;
        time_reg_sec_in <= host_sec;
      end

      if (host_take && (host_op == 2'b01)) begin
        period_in <= host_val;
      end else if (srv_take && !srv_op) begin
        period_in <= srv_val;
      end

      if (abort) begin
        remaining <= '0;
      end else if (host_take && (host_op == 2'b10)) begin
        remaining <= host_val;
      end else if (srv_take && srv_op) begin
        remaining <= srv_val;
      end else if (adj_ld) begin
        remaining <= remaining - step;
      end

      // WAIT lasts ADJ_DELAY+3 cycles: the counter runs ADJ_DELAY+2 down to 0.
      if (adj_ld) begin
        adj_q    <= step;
        wait_cnt <= {1'b0, ADJ_DELAY} + 33'd2;
      end else if ((state == S_WAIT) && (wait_cnt != 33'd0)) begin
        wait_cnt <= wait_cnt - 33'd1;
      end
    end
  end

endmodule
